// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and entry type for the Lucid64 fetch stage.
package fetch_stage_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_ST_REQ  = 2'd0,
    FETCH_ST_WAIT = 2'd1,
    FETCH_ST_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding {inst, pc}; flush beats load, load beats drain.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output fetch_entry_t entry_o
);

  logic         full_q, full_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      entry_d = entry_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Lucid64 instruction fetch: single-outstanding imem requests, redirect kill,
// registered decode outputs with a one-entry skid buffer behind stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o
);

  fetch_state_e fsm_q, fsm_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  inflight_pc_q, inflight_pc_d;
  logic         kill_q, kill_d;
  logic         valid_q, valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  next_pc_q, next_pc_d;

  logic         skid_load, skid_drain, skid_flush, skid_full;
  fetch_entry_t skid_out, rsp_entry;
  logic         rsp_live;

  assign rsp_entry = '{inst: imem_rdata_i, pc: inflight_pc_q};
  assign rsp_live  = (fsm_q == FETCH_ST_WAIT) && imem_rvalid_i && !kill_q;

  fetch_skid_buffer u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .entry_i (rsp_entry),
    .full_o  (skid_full),
    .entry_o (skid_out)
  );

  always_comb begin
    fsm_d         = fsm_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    valid_d       = valid_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    next_pc_d     = next_pc_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_flush    = 1'b0;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~64'h3;
      valid_d    = 1'b0;
      inst_d     = INST_NOP;
      skid_flush = 1'b1;
      // A response landing in the redirect cycle is the one a kill would wait for.
      case (fsm_q)
        FETCH_ST_REQ: begin
          if (imem_gnt_i) begin
            fsm_d  = FETCH_ST_WAIT;
            kill_d = 1'b1;
          end
        end
        FETCH_ST_WAIT: begin
          if (imem_rvalid_i) begin
            fsm_d  = FETCH_ST_REQ;
            kill_d = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: fsm_d = FETCH_ST_REQ;
      endcase
    end else begin
      case (fsm_q)
        FETCH_ST_REQ: begin
          if (imem_gnt_i) begin
            fsm_d         = FETCH_ST_WAIT;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = pc_plus4(fetch_pc_q);
          end
        end
        FETCH_ST_WAIT: begin
          if (imem_rvalid_i) begin
            kill_d = 1'b0;
            fsm_d  = (rsp_live && stall_i && valid_q) ? FETCH_ST_HOLD : FETCH_ST_REQ;
          end
        end
        FETCH_ST_HOLD: begin
          if (!stall_i) fsm_d = FETCH_ST_REQ;
        end
        default: fsm_d = FETCH_ST_REQ;
      endcase

      if (!stall_i) begin
        if (skid_full) begin
          valid_d    = 1'b1;
          inst_d     = skid_out.inst;
          pc_d       = skid_out.pc;
          next_pc_d  = pc_plus4(skid_out.pc);
          skid_drain = 1'b1;
          skid_load  = rsp_live;
        end else if (rsp_live) begin
          valid_d   = 1'b1;
          inst_d    = imem_rdata_i;
          pc_d      = inflight_pc_q;
          next_pc_d = pc_plus4(inflight_pc_q);
        end else begin
          valid_d = 1'b0;
          inst_d  = INST_NOP;
        end
      end else if (rsp_live) begin
        if (!valid_q) begin
          valid_d   = 1'b1;
          inst_d    = imem_rdata_i;
          pc_d      = inflight_pc_q;
          next_pc_d = pc_plus4(inflight_pc_q);
        end else begin
          skid_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q         <= FETCH_ST_REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      valid_q       <= 1'b0;
      inst_q        <= INST_NOP;
      pc_q          <= '0;
      next_pc_q     <= '0;
    end else begin
      fsm_q         <= fsm_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      valid_q       <= valid_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      next_pc_q     <= next_pc_d;
    end
  end

  // Reset forces the state to REQ, so the request is masked while reset is held.
  assign imem_req_o  = (fsm_q == FETCH_ST_REQ) && !rst_i;
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = valid_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_q;
  assign next_pc_o   = next_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: bench-side memory, directed scenarios, then randomized traffic
// checked every cycle against a program-order stream model.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC_T = 64'h1000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk_i, rst_i, stall_i, redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [63:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o, next_pc_o;

  fetch_stage #(.RESET_PC(RESET_PC_T)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .next_pc_o     (next_pc_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 32'h0050_0093;
    if (a == 64'h1004) return 32'h00A0_0113;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_3C3C;
  endfunction

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Bench memory: one outstanding grant, response latency in [min_lat, max_lat] cycles
  // after the grant cycle; a grant cut off by reset returns a stray response afterwards.
  int          gnt_pct = 100;
  int          min_lat = 0;
  int          max_lat = 0;
  int          lat_cnt = 0;
  logic        mem_out = 1'b0;
  logic        stray   = 1'b0;
  logic [63:0] mem_addr = '0;

  always begin
    @(posedge clk_i);
    #1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    if (rst_i) begin
      if (mem_out) stray = 1'b1;
      mem_out = 1'b0;
    end else if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      stray         = 1'b0;
    end else if (mem_out) begin
      if (lat_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mem_addr);
        mem_out       = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (imem_req_o && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt_i = 1'b1;
      mem_out    = 1'b1;
      mem_addr   = imem_addr_o;
      lat_cnt    = int'($urandom_range(max_lat, min_lat));
    end
  end

  // Stream model: presented instructions follow program order from RESET_PC, restarting
  // at each redirect target; granted addresses follow the same rule.
  logic [63:0] exp_pc, exp_fetch;
  logic        p_valid = 1'b0, p_stall = 1'b0, p_redir = 1'b0;
  logic [31:0] p_inst;
  logic [63:0] p_pc, p_next;

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_pc", pc_o, 64'h0);
      chk("rst_next_pc", next_pc_o, 64'h0);
      exp_pc    = RESET_PC_T;
      exp_fetch = RESET_PC_T;
      p_valid   = 1'b0;
      p_stall   = 1'b0;
      p_redir   = 1'b0;
    end else begin
      if (p_redir) chk("valid_after_redirect", valid_o, 1'b0);
      if (p_stall && p_valid && !p_redir) begin
        chk("stall_hold_valid", valid_o, 1'b1);
        chk("stall_hold_inst", inst_o, p_inst);
        chk("stall_hold_pc", pc_o, p_pc);
        chk("stall_hold_next_pc", next_pc_o, p_next);
      end
      if (valid_o) begin
        chk("stream_pc", pc_o, exp_pc);
        chk("stream_inst", inst_o, mem_word(pc_o));
        chk("stream_next_pc", next_pc_o, pc_o + 64'd4);
      end else begin
        chk("idle_inst_nop", inst_o, NOP);
      end
      chk("single_outstanding", imem_req_o && mem_out && !imem_gnt_i, 1'b0);
      if (imem_req_o && imem_gnt_i) begin
        chk("grant_addr", imem_addr_o, exp_fetch);
        exp_fetch = exp_fetch + 64'd4;
      end
      if (redirect_i) begin
        exp_pc    = redirect_pc_i & ~64'h3;
        exp_fetch = redirect_pc_i & ~64'h3;
      end else if (valid_o && !stall_i) begin
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      p_valid = valid_o;
      p_stall = stall_i;
      p_redir = redirect_i;
      p_inst  = inst_o;
      p_pc    = pc_o;
      p_next  = next_pc_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;

    // Reset release and first fetch with a 1-cycle memory.
    tick();
    chk("d_first_req", imem_req_o, 1'b1);
    chk("d_first_addr", imem_addr_o, 64'h1000);
    tick();
    tick();
    chk("d_first_valid", valid_o, 1'b1);
    chk("d_first_pc", pc_o, 64'h1000);
    chk("d_first_next_pc", next_pc_o, 64'h1004);
    chk("d_first_inst", inst_o, 32'h0050_0093);
    chk("d_second_addr", imem_addr_o, 64'h1004);

    // Stall for three cycles while the 0x1004 response arrives.
    stall_i = 1'b1;
    tick();
    tick();
    chk("d_hold_noreq", imem_req_o, 1'b0);
    chk("d_hold_pc", pc_o, 64'h1000);
    tick();
    stall_i = 1'b0;
    min_lat = 2;
    max_lat = 2;
    tick();
    chk("d_drain_valid", valid_o, 1'b1);
    chk("d_drain_pc", pc_o, 64'h1004);
    chk("d_drain_inst", inst_o, 32'h00A0_0113);
    chk("d_resume_req", imem_req_o, 1'b1);
    chk("d_resume_addr", imem_addr_o, 64'h1008);

    // Redirect while waiting on the 0x1008 response.
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h2003;
    tick();
    redirect_i = 1'b0;
    min_lat    = 0;
    max_lat    = 0;
    chk("d_redir_addr", imem_addr_o, 64'h2000);
    chk("d_redir_valid", valid_o, 1'b0);
    tick();
    tick();
    chk("d_kill_valid", valid_o, 1'b0);
    chk("d_kill_req", imem_req_o, 1'b1);
    chk("d_kill_addr", imem_addr_o, 64'h2000);
    tick();
    chk("d_target_wait_valid", valid_o, 1'b0);
    tick();
    chk("d_target_valid", valid_o, 1'b1);
    chk("d_target_pc", pc_o, 64'h2000);
    chk("d_target_next_pc", next_pc_o, 64'h2004);

    // Redirect in REQ coinciding with a grant.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h3000;
    tick();
    redirect_i = 1'b0;
    chk("d_gntredir_valid", valid_o, 1'b0);
    tick();
    chk("d_gntredir_req", imem_req_o, 1'b1);
    chk("d_gntredir_addr", imem_addr_o, 64'h3000);
    tick();
    tick();
    chk("d_gntredir_pc", pc_o, 64'h3000);
    chk("d_gntredir_tvalid", valid_o, 1'b1);

    // Redirect while stalled with the skid buffer full.
    stall_i = 1'b1;
    tick();
    tick();
    chk("d_full_noreq", imem_req_o, 1'b0);
    chk("d_full_pc", pc_o, 64'h3000);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h4000;
    tick();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    chk("d_flush_valid", valid_o, 1'b0);
    chk("d_flush_req", imem_req_o, 1'b1);
    chk("d_flush_addr", imem_addr_o, 64'h4000);
    tick();
    min_lat = 2;
    max_lat = 2;
    tick();
    chk("d_flush_pc", pc_o, 64'h4000);
    chk("d_flush_tvalid", valid_o, 1'b1);

    // Asynchronous reset pulse while waiting, followed by a stray response.
    tick();
    #2 rst_i = 1'b1;
    min_lat = 0;
    max_lat = 0;
    tick();
    chk("d_arst_valid", valid_o, 1'b0);
    chk("d_arst_req", imem_req_o, 1'b0);
    tick();
    #2 rst_i = 1'b0;
    tick();
    chk("d_restart_req", imem_req_o, 1'b1);
    chk("d_restart_addr", imem_addr_o, 64'h1000);
    chk("d_restart_valid", valid_o, 1'b0);
    tick();
    tick();
    tick();
    chk("d_restart_pvalid", valid_o, 1'b1);
    chk("d_restart_pc", pc_o, 64'h1000);
    chk("d_restart_inst", inst_o, 32'h0050_0093);

    // Randomized traffic.
    gnt_pct = 70;
    min_lat = 0;
    max_lat = 3;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) begin
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        #2 rst_i = 1'b1;
        tick();
        tick();
        #2 rst_i = 1'b0;
      end else begin
        stall_i = ($urandom_range(99) < 30);
        if (!redirect_i && ($urandom_range(99) < 3)) begin
          redirect_i = 1'b1;
          if ($urandom_range(3) == 0)
            redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
          else
            redirect_pc_i = {$urandom(), $urandom()};
        end else begin
          redirect_i = 1'b0;
        end
      end
    end
    tick();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    repeat (10) tick();
    chk("liveness", consumed >= 150, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the Lucid64 pipeline. Owns the fetch PC, issues single-outstanding requests on the instruction-memory req/gnt/rvalid interface, and presents `pc`, `next_pc`, `inst` and `valid` to `decode_stage` as registered outputs. Handles redirects from execute by discarding in-flight responses. Holds back-pressure from the hazard unit with a one-entry skid buffer, so no memory response is ever dropped.

## Interface
- `RESET_PC`, default `` `RESET_PC `` (64'h0), first fetch address after reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `stall_i`  in  1  decode is stalled; hold all `*_o` pipeline outputs.
- `redirect_i`  in  1  single-cycle pulse: branch taken or jump resolved in execute.
- `redirect_pc_i`  in  64  redirect target; bits [1:0] are forced to 0.
- `imem_req_o`  out  1  instruction-memory request.
- `imem_addr_o`  out  64  request address; always equals the fetch PC.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid; at least 1 cycle after `gnt`.
- `imem_rdata_i`  in  32  instruction word.
- `valid_o`  out  1  `inst_o`, `pc_o` and `next_pc_o` hold a live instruction.
- `inst_o`  out  32  fetched instruction.
- `pc_o`  out  64  address of `inst_o`.
- `next_pc_o`  out  64  `pc_o + 4`, with 64-bit wrap.

## Operation
- Fetch FSM states:
  - REQ: `imem_req_o=1`.
  - WAIT: granted, awaiting `rvalid`.
  - HOLD: skid buffer full, no request issued.
- Transitions:
  - REQ→WAIT on `gnt`. Latch the issued PC into `inflight_pc`. Advance `fetch_pc` by 4.
  - WAIT→REQ on `rvalid` when the response can be absorbed.
  - WAIT→HOLD on `rvalid` when `stall_i=1` and the output register is occupied (`valid_o=1`).
  - HOLD→REQ on the cycle the buffer drains.
- Response routing:
  - If `stall_i=0`, the output register loads the skid buffer if it is full, else the response.
  - When the output register loads the skid buffer, a response arriving in the same cycle goes into the buffer.
  - If `stall_i=1` and `valid_o=0`, the response loads the output register directly. This is the stall-on-empty case.
- Redirect has priority over stall and over every FSM transition:
  - `fetch_pc` ← `{redirect_pc_i[63:2],2'b00}`.
  - `valid_o` ← 0 and the skid buffer is emptied on the next edge.
  - Redirect in WAIT, or in REQ with `gnt` the same cycle: set `kill`. The next `rvalid` is consumed and discarded, `kill` clears, and the FSM goes to REQ.
  - Redirect in REQ without `gnt`: the request is retracted. `imem_addr_o` shows the target from the next cycle. The imem interface permits address change while ungranted.
  - Redirect in HOLD: go to REQ.
- At most one request is outstanding. `gnt` is never expected in WAIT or HOLD.
- When `valid_o=0`, `inst_o` carries `` `INST_NOP `` (32'h00000013).

## Timing
- During reset, and for the values held immediately after it: `imem_req_o`=0, `valid_o`=0, `inst_o`=`` `INST_NOP ``, `pc_o`=0, `next_pc_o`=0, `fetch_pc`=`RESET_PC`, FSM=REQ, `kill`=0, skid buffer empty.
  - `imem_req_o` is a decode of FSM=REQ.
  - The first request is visible in the first cycle after `rst_i` deasserts.
- Latency:
  - `rvalid` in cycle N gives `valid_o=1` in N+1, when unstalled.
  - With `rvalid` in N, the next request is visible in N+1.
  - With a 1-cycle memory, throughput is 1 instruction per 2 cycles.
- Stall: `valid_o`, `inst_o`, `pc_o` and `next_pc_o` are held exactly while `stall_i=1`. The one exception is the stall-on-empty load.
- Reset mid-transaction: the FSM returns to REQ with `kill`=0. A late `rvalid` from before reset is ignored because the FSM is in REQ.

## Structure
- `Lucid64.vh` gains:
  - `` `RESET_PC ``
  - `` `INST_NOP ``
  - `` `FETCH_ST_REQ ``, `` `FETCH_ST_WAIT ``, `` `FETCH_ST_HOLD `` (2-bit encodings)
- Sub-module `fetch_skid_buffer`: one entry of {inst, pc}, with full flag, load, drain and flush.

## Test plan
- Reset release, `RESET_PC`=0x1000, memory returns 0x00500093 one cycle after `gnt` → `imem_addr_o`=0x1000; next cycle `valid_o`=1, `pc_o`=0x1000, `next_pc_o`=0x1004; then request to 0x1004.
- `stall_i` held 3 cycles with `valid_o=1` while `rvalid` returns 0x00A00113 for 0x1004 → outputs unchanged, FSM=HOLD, no `imem_req_o`; the cycle after the stall drops, `pc_o`=0x1004, then the request to 0x1008 resumes.
- `redirect_i` with target 0x2003 while in WAIT for 0x1008 → the 0x1008 response is discarded; the next request is to 0x2000; `valid_o` stays 0 until the 0x2000 response.
- `redirect_i` in REQ with `gnt` the same cycle → `kill` is set, one response is dropped, the next request is to the target.
- `redirect_i` with `stall_i=1` and the skid buffer full → next cycle `valid_o`=0, buffer empty, FSM=REQ to the target.
- Async `rst_i` pulse mid-WAIT, followed by a stray `rvalid` → outputs at reset values; the stray response is never presented; fetch restarts at `RESET_PC`.
